// File: rtl/rd_burst_scheduler_pkg.sv
// Shared definitions for the read-burst scheduler: FSM encoding, error flag
// bit positions, and a saturating counter helper.
package rd_burst_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int ERR_RESP = 0;
  localparam int ERR_LAST = 1;
  localparam int ERR_CFG  = 2;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/rd_beat_checker.sv
// Monitors accepted R beats: counts them, tracks the in-burst beat index and
// accumulates response and RLAST-placement errors.
module rd_beat_checker
  import rd_burst_scheduler_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        beat,
  input  logic        last,
  input  logic [1:0]  resp,
  input  logic [7:0]  burst_len,
  input  logic        outstanding_zero,
  output logic [31:0] beat_count,
  output logic        resp_err,
  output logic        last_err
);

  logic [31:0] beat_count_reg;
  logic [7:0]  beat_idx_reg;
  logic        resp_err_reg;
  logic        last_err_reg;
  logic        idx_at_end;

  assign idx_at_end = (beat_idx_reg == burst_len - 8'd1);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      beat_count_reg <= 32'd0;
      beat_idx_reg   <= 8'd0;
      resp_err_reg   <= 1'b0;
      last_err_reg   <= 1'b0;
    end else if (beat) begin
      beat_count_reg <= sat_inc(beat_count_reg);
      beat_idx_reg   <= last ? 8'd0 : beat_idx_reg + 8'd1;
      if (resp != RESP_OKAY)
        resp_err_reg <= 1'b1;
      // A beat with nothing outstanding is as much a framing fault as a misplaced RLAST.
      if ((last != idx_at_end) || outstanding_zero)
        last_err_reg <= 1'b1;
    end
  end

  assign beat_count = beat_count_reg;
  assign resp_err   = resp_err_reg;
  assign last_err   = last_err_reg;

endmodule

// File: rtl/rd_burst_scheduler.sv
// Issues a run of fixed-length read bursts to a read-stream engine, bounds the
// number in flight, and reports beat/cycle counts and sticky errors.
module rd_burst_scheduler
  import rd_burst_scheduler_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int BEAT_BYTES      = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [7:0]  burst_len,
  input  logic [15:0] num_bursts,
  output logic        busy,
  output logic        done,
  output logic [2:0]  err_flags,
  output logic [31:0] beat_count,
  output logic [31:0] cycle_count,
  output logic        rs_en,
  output logic [31:0] rs_addr,
  output logic [7:0]  rs_burst_length,
  input  logic        rs_finish,
  input  logic        r_valid,
  input  logic        r_ready,
  input  logic        r_last,
  input  logic [1:0]  r_resp
);

  localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

  state_t      state_reg;
  logic [31:0] addr_reg;
  logic [7:0]  len_reg;
  logic [15:0] num_reg;
  logic [15:0] issued_reg;
  logic [3:0]  outstanding_reg;
  logic        busy_reg;
  logic        done_reg;
  logic        cfg_err_reg;
  logic [31:0] cycle_reg;

  logic        beat;
  logic        addr_hs;
  logic        burst_done;
  logic        accept_start;
  logic [31:0] stride;
  logic        resp_err;
  logic        last_err;

  assign accept_start = (state_reg == ST_IDLE) && start;
  assign beat         = busy_reg && r_valid && r_ready;
  assign addr_hs      = rs_en && rs_finish;
  assign burst_done   = beat && r_last && (outstanding_reg != 4'd0);
  assign stride       = {24'd0, len_reg} * 32'(BEAT_BYTES);

  // Pure register decode so the engine never sees a combinational path from its own handshake.
  assign rs_en = (state_reg == ST_ISSUE) && (issued_reg < num_reg) && (outstanding_reg < MAX_OUT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      addr_reg        <= 32'd0;
      len_reg         <= 8'd0;
      num_reg         <= 16'd0;
      issued_reg      <= 16'd0;
      outstanding_reg <= 4'd0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      cfg_err_reg     <= 1'b0;
      cycle_reg       <= 32'd0;
    end else begin
      done_reg <= 1'b0;
      if (busy_reg)
        cycle_reg <= sat_inc(cycle_reg);
      if (addr_hs) begin
        issued_reg <= issued_reg + 16'd1;
        addr_reg   <= addr_reg + stride;
      end
      if (addr_hs && !burst_done)
        outstanding_reg <= outstanding_reg + 4'd1;
      else if (!addr_hs && burst_done)
        outstanding_reg <= outstanding_reg - 4'd1;

      unique case (state_reg)
        ST_IDLE: begin
          if (start) begin
            addr_reg        <= base_addr;
            len_reg         <= burst_len;
            num_reg         <= num_bursts;
            issued_reg      <= 16'd0;
            outstanding_reg <= 4'd0;
            cycle_reg       <= 32'd0;
            cfg_err_reg     <= (burst_len == 8'd0);
            if ((burst_len == 8'd0) || (num_bursts == 16'd0)) begin
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= ST_ISSUE;
              busy_reg  <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (issued_reg == num_reg)
            state_reg <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (outstanding_reg == 4'd0) begin
            state_reg <= ST_DONE;
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  rd_beat_checker u_beat_checker (
    .clk              (clk),
    .reset            (reset),
    .clear            (accept_start),
    .beat             (beat),
    .last             (r_last),
    .resp             (r_resp),
    .burst_len        (len_reg),
    .outstanding_zero (outstanding_reg == 4'd0),
    .beat_count       (beat_count),
    .resp_err         (resp_err),
    .last_err         (last_err)
  );

  assign busy            = busy_reg;
  assign done            = done_reg;
  assign cycle_count     = cycle_reg;
  assign rs_addr         = addr_reg;
  assign rs_burst_length = len_reg;

  always_comb begin
    err_flags           = 3'b000;
    err_flags[ERR_RESP] = resp_err;
    err_flags[ERR_LAST] = last_err;
    err_flags[ERR_CFG]  = cfg_err_reg;
  end

endmodule

// File: tb/tb_rd_burst_scheduler.sv
// Randomized bench for rd_burst_scheduler with a transaction-level reference
// model (expected addresses, in-flight bursts, beat/error/cycle totals).
module tb_rd_burst_scheduler;

  localparam int MAX = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] base_addr;
  logic [7:0]  burst_len;
  logic [15:0] num_bursts;
  logic        busy;
  logic        done;
  logic [2:0]  err_flags;
  logic [31:0] beat_count;
  logic [31:0] cycle_count;
  logic        rs_en;
  logic [31:0] rs_addr;
  logic [7:0]  rs_burst_length;
  logic        rs_finish;
  logic        r_valid;
  logic        r_ready;
  logic        r_last;
  logic [1:0]  r_resp;

  always #5 clk = ~clk;

  rd_burst_scheduler #(.MAX_OUTSTANDING(MAX), .BEAT_BYTES(64)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .base_addr       (base_addr),
    .burst_len       (burst_len),
    .num_bursts      (num_bursts),
    .busy            (busy),
    .done            (done),
    .err_flags       (err_flags),
    .beat_count      (beat_count),
    .cycle_count     (cycle_count),
    .rs_en           (rs_en),
    .rs_addr         (rs_addr),
    .rs_burst_length (rs_burst_length),
    .rs_finish       (rs_finish),
    .r_valid         (r_valid),
    .r_ready         (r_ready),
    .r_last          (r_last),
    .r_resp          (r_resp)
  );

  int checks = 0;
  int errors = 0;

  // Test configuration and responder knobs
  logic [31:0] t_base;
  int t_len, t_n;
  int rdelay, ar_pct, v_pct, rdy_pct, resp_err_pct;
  int inj_resp_idx, inj_last_idx;

  // Reference model state
  int unsigned cyc = 0;
  int due[$];
  int r_idx, r_burst;
  int issued_m, out_m, beats_m, done_cnt, m_cyc;
  logic [2:0] err_m;
  bit m_active;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_cycle();
    logic exp_en, ar_hs, beat_hs, last_s, done_s, rst_s, cnt;
    logic [1:0] resp_s;
    logic [31:0] ea;
    int out_pre;
    rs_finish = rs_en && ($urandom_range(99) < ar_pct);
    if (due.size() > 0 && due[0] <= int'(cyc)) begin
      r_valid = ($urandom_range(99) < v_pct);
      r_last  = (r_idx == t_len - 1) || (r_burst == 0 && r_idx == inj_last_idx);
      if (r_burst == 0 && r_idx == inj_resp_idx) r_resp = 2'b10;
      else if ($urandom_range(99) < resp_err_pct) r_resp = 2'($urandom_range(3, 1));
      else r_resp = 2'b00;
    end else begin
      r_valid = 1'b0;
      r_last  = 1'($urandom_range(1));
      r_resp  = 2'b00;
    end
    r_ready = ($urandom_range(99) < rdy_pct);

    @(negedge clk);
    exp_en = m_active && (issued_m < t_n) && (out_m < MAX);
    chk("rs_en", 32'(rs_en), 32'(exp_en));
    if (rs_en) chk("rs_burst_length", 32'(rs_burst_length), 32'(t_len));
    ar_hs = rs_en && rs_finish;
    if (ar_hs) begin
      ea = t_base + 32'(issued_m) * 32'(t_len) * 32'd64;
      chk("rs_addr", rs_addr, ea);
    end
    done_s = done;
    rst_s  = reset;
    if (done_s) begin
      done_cnt++;
      chk("done_when_drained", 32'(out_m == 0 && (issued_m == t_n || t_len == 0)), 32'd1);
    end
    chk("busy", 32'(busy), 32'(m_active && !done_s));
    if (m_active && !done_s) m_cyc++;
    beat_hs = r_valid && r_ready;
    last_s  = r_last;
    resp_s  = r_resp;

    @(posedge clk);
    #1;
    cyc++;
    cnt = m_active && !done_s && !rst_s;
    out_pre = out_m;
    if (beat_hs) begin
      if (cnt) begin
        beats_m++;
        if (resp_s != 2'b00) err_m[0] = 1'b1;
        if (last_s != (r_idx == t_len - 1)) err_m[1] = 1'b1;
        if (out_pre == 0) err_m[1] = 1'b1;
        else if (last_s) out_m--;
      end
      if (last_s) begin
        r_idx = 0;
        if (due.size() > 0) void'(due.pop_front());
        r_burst++;
      end else begin
        r_idx++;
      end
    end
    if (ar_hs && !rst_s) begin
      issued_m++;
      out_m++;
      due.push_back(int'(cyc) + rdelay);
    end
    if (done_s || rst_s) m_active = 1'b0;
    if (rst_s) begin
      issued_m = 0;
      out_m    = 0;
    end
  endtask

  task automatic begin_test(input logic [31:0] b, input int len, input int n);
    t_base = b; t_len = len; t_n = n;
    issued_m = 0; out_m = 0; beats_m = 0; done_cnt = 0; m_cyc = 0;
    r_idx = 0; r_burst = 0;
    due.delete();
    err_m = {(len == 0), 2'b00};
    start = 1'b1;
    base_addr = b;
    burst_len = len[7:0];
    num_bursts = n[15:0];
    rs_finish = 1'b0;
    r_valid = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    start = 1'b0;
    m_active = (len != 0) && (n != 0);
  endtask

  task automatic run_test(input string name, input logic [31:0] b, input int len, input int n,
                          input int timeout);
    begin_test(b, len, n);
    for (int i = 0; i < timeout && done_cnt == 0; i++) do_cycle();
    chk({name, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
    chk({name, "_beat_count"}, beat_count, 32'(beats_m));
    chk({name, "_err_flags"}, 32'(err_flags), 32'(err_m));
    chk({name, "_cycle_count"}, cycle_count, 32'(m_cyc));
    repeat (3) do_cycle();
    chk({name, "_single_done"}, 32'(done_cnt), 32'd1);
    chk({name, "_beat_count_hold"}, beat_count, 32'(beats_m));
    $display("test %s base=0x%08h len=%0d bursts=%0d beats=%0d err=%03b cycles=%0d",
             name, b, len, n, beats_m, err_m, m_cyc);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; burst_len = '0; num_bursts = '0;
    rs_finish = 1'b0; r_valid = 1'b0; r_ready = 1'b0; r_last = 1'b0; r_resp = 2'b00;
    t_len = 1; t_n = 0; rdelay = 0; ar_pct = 100; v_pct = 100; rdy_pct = 100;
    resp_err_pct = 0; inj_resp_idx = -1; inj_last_idx = -1; m_active = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_rs_en", 32'(rs_en), 32'd0);
    chk("reset_err", 32'(err_flags), 32'd0);
    chk("reset_beats", beat_count, 32'd0);
    chk("reset_cycles", cycle_count, 32'd0);
    chk("reset_rs_addr", rs_addr, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Basic run with an ideal responder
    run_test("basic", 32'h1000_0000, 16, 4, 600);
    chk("basic_beats_64", beat_count, 32'd64);
    chk("basic_err_zero", 32'(err_flags), 32'd0);

    // Back-pressure: long R latency with only two bursts allowed in flight
    rdelay = 50;
    run_test("backpressure", 32'h0000_4000, 4, 8, 2000);

    // Address wrap-around
    rdelay = 2;
    run_test("wrap", 32'hFFFF_FF00, 4, 2, 300);

    // Degenerate configurations
    run_test("zero_bursts", 32'h0000_1000, 8, 0, 2);
    chk("zero_bursts_err", 32'(err_flags), 32'd0);
    run_test("zero_len", 32'h0000_1000, 0, 3, 2);
    chk("zero_len_err", 32'(err_flags), 32'b100);

    // Injected RRESP error on beat 3 and early RLAST on beat 5 of the first burst
    rdelay = 1; inj_resp_idx = 2; inj_last_idx = 4;
    run_test("errors", 32'h0002_0000, 16, 3, 1000);
    chk("errors_flags_011", 32'(err_flags), 32'b011);
    inj_resp_idx = -1; inj_last_idx = -1;

    // Single-beat bursts with zero latency: completions coincide with new handshakes
    rdelay = 0;
    run_test("simultaneous", 32'h0003_0000, 1, 6, 200);

    // Randomized runs
    for (int k = 0; k < 6; k++) begin
      ar_pct = $urandom_range(100, 30);
      v_pct = $urandom_range(100, 50);
      rdy_pct = $urandom_range(100, 50);
      rdelay = $urandom_range(10, 0);
      resp_err_pct = 3;
      run_test("random", $urandom, $urandom_range(20, 1), $urandom_range(6, 1), 4000);
    end
    resp_err_pct = 0; ar_pct = 100; v_pct = 100; rdy_pct = 100;

    // Reset in the middle of the drain phase
    rdelay = 30;
    begin_test(32'h0000_2000, 8, 2);
    for (int i = 0; i < 20 && issued_m < t_n; i++) do_cycle();
    repeat (3) do_cycle();
    reset = 1'b1;
    do_cycle();
    reset = 1'b0;
    @(negedge clk);
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_done", 32'(done), 32'd0);
    chk("midreset_rs_en", 32'(rs_en), 32'd0);
    chk("midreset_err", 32'(err_flags), 32'd0);
    chk("midreset_beats", beat_count, 32'd0);
    chk("midreset_cycles", cycle_count, 32'd0);
    chk("midreset_rs_addr", rs_addr, 32'd0);
    chk("midreset_rs_len", 32'(rs_burst_length), 32'd0);
    @(posedge clk);
    #1;
    cyc++;
    repeat (60) do_cycle();
    chk("stale_beats_ignored", beat_count, 32'd0);
    chk("stale_err_ignored", 32'(err_flags), 32'd0);
    due.delete();
    rdelay = 3;
    run_test("after_reset", 32'h0000_8000, 8, 3, 500);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
